// File: rtl/uop_issue_queue_pkg.sv
// Shared types for the micro-op issue queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uop_issue_queue_pkg;

  localparam int UOP_W      = 20;
  localparam int K_W        = 16;
  localparam int MAX_BUNDLE = 3;

  // One queue slot: the uop, its bundle constant and an end-of-bundle marker.
  typedef struct packed {
    logic             last;
    logic [K_W-1:0]   k;
    logic [UOP_W-1:0] uop;
  } uop_entry_t;

endpackage

// File: rtl/uop_queue_mem.sv
// Register-array storage for the issue queue: three write lanes, one async read.
// Latency: writes land on the next edge; read data follows i_rd_ptr combinationally.
// Backpressure: none; the parent only enables lanes that have free slots.
module uop_queue_mem
  import uop_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic [AW-1:0]                    i_wr_ptr,
  input  logic [MAX_BUNDLE-1:0]            i_wr_en,
  input  uop_entry_t [MAX_BUNDLE-1:0]      i_wr_dat,
  input  logic [AW-1:0]                    i_rd_ptr,
  output uop_entry_t                       o_rd_dat
);

  uop_entry_t r_mem [DEPTH];

  // Lane i writes slot wr_ptr+i; pointer addition wraps naturally at DEPTH.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_BUNDLE; i++) begin
      if (i_wr_en[i]) begin
        r_mem[i_wr_ptr + AW'(i)] <= i_wr_dat[i];
      end
    end
  end

  assign o_rd_dat = r_mem[i_rd_ptr];

endmodule

// File: rtl/uop_issue_queue.sv
// Buffers 0-3 uop bundles from the front end and issues one uop per cycle.
// Latency: bundle accepted in cycle N is at the issue port in N+1 (no bypass).
// Backpressure: ex_feed_req drops when fewer than 3 slots are free; issue is valid/ready.
module uop_issue_queue
  import uop_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ex_feed_req,
  input  logic             ex_feed_ack,
  input  logic [UOP_W-1:0] ex_uop_0,
  input  logic [UOP_W-1:0] ex_uop_1,
  input  logic [UOP_W-1:0] ex_uop_2,
  input  logic [1:0]       ex_uop_count,
  input  logic [K_W-1:0]   ex_k,
  input  logic             ex_pc_w,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [UOP_W-1:0] iss_uop,
  output logic [K_W-1:0]   iss_k,
  output logic             iss_last,
  output logic [AW:0]      occupancy
);

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_cnt;

  logic [AW:0]                   w_free;
  logic                          w_enq;
  logic                          w_deq;
  logic [AW:0]                   w_add;
  logic [MAX_BUNDLE-1:0]         w_lane_en;
  uop_entry_t [MAX_BUNDLE-1:0]   w_wr_dat;
  logic [UOP_W-1:0]              w_lane_uop [MAX_BUNDLE];
  uop_entry_t                    w_head;

  // Request depends only on state, reset and redirect so the ack path never loops back.
  assign w_free      = AW'(0) + (AW+1)'(DEPTH) - r_cnt;
  assign ex_feed_req = ~rst & ~ex_pc_w & (w_free >= (AW+1)'(MAX_BUNDLE));
  assign w_enq       = ex_feed_req & ex_feed_ack & ~ex_pc_w;
  assign iss_valid   = (r_cnt != '0);
  assign w_deq       = iss_valid & iss_ready;
  assign w_add       = w_enq ? (AW+1)'(ex_uop_count) : '0;

  assign w_lane_uop[0] = ex_uop_0;
  assign w_lane_uop[1] = ex_uop_1;
  assign w_lane_uop[2] = ex_uop_2;

  // Build per-lane entries: constant replicated, last marks lane count-1.
  always_comb begin
    w_lane_en = '0;
    w_wr_dat  = '0;
    for (int i = 0; i < MAX_BUNDLE; i++) begin
      w_lane_en[i]     = w_enq & (ex_uop_count > 2'(i));
      w_wr_dat[i].uop  = w_lane_uop[i];
      w_wr_dat[i].k    = ex_k;
      w_wr_dat[i].last = (2'(i) == (ex_uop_count - 2'd1));
    end
  end

  // Pointer and count state; flush and reset both return the queue to empty.
  always_ff @(posedge clk) begin
    if (rst || ex_pc_w) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_add);
      r_rd_ptr <= r_rd_ptr + AW'(w_deq);
      r_cnt    <= r_cnt + w_add - (AW+1)'(w_deq);
    end
  end

  uop_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk      (clk),
    .i_wr_ptr (r_wr_ptr),
    .i_wr_en  (w_lane_en),
    .i_wr_dat (w_wr_dat),
    .i_rd_ptr (r_rd_ptr),
    .o_rd_dat (w_head)
  );

  assign iss_uop   = w_head.uop;
  assign iss_k     = w_head.k;
  assign iss_last  = w_head.last;
  assign occupancy = r_cnt;

endmodule

// File: tb/tb_uop_issue_queue.sv
// Directed plus randomised bench for uop_issue_queue with an issue-order scoreboard.
// Latency: inputs change 1 time unit after posedge; outputs sampled at negedge.
// Backpressure: iss_ready driven per step, randomised in the stream phase.
module tb_uop_issue_queue;
  import uop_issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_feed_req;
  logic             ex_feed_ack;
  logic [UOP_W-1:0] ex_uop_0, ex_uop_1, ex_uop_2;
  logic [1:0]       ex_uop_count;
  logic [K_W-1:0]   ex_k;
  logic             ex_pc_w;
  logic             iss_valid;
  logic             iss_ready;
  logic [UOP_W-1:0] iss_uop;
  logic [K_W-1:0]   iss_k;
  logic             iss_last;
  logic [AW:0]      occupancy;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  uop_entry_t sb [$];

  uop_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_feed_req  (ex_feed_req),
    .ex_feed_ack  (ex_feed_ack),
    .ex_uop_0     (ex_uop_0),
    .ex_uop_1     (ex_uop_1),
    .ex_uop_2     (ex_uop_2),
    .ex_uop_count (ex_uop_count),
    .ex_k         (ex_k),
    .ex_pc_w      (ex_pc_w),
    .iss_valid    (iss_valid),
    .iss_ready    (iss_ready),
    .iss_uop      (iss_uop),
    .iss_k        (iss_k),
    .iss_last     (iss_last),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue monitor: every cycle check valid against the model, pop on handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("iss_valid", {31'd0, iss_valid}, {31'd0, sb.size() != 0});
      if (iss_valid === 1'b1 && iss_ready === 1'b1 && sb.size() != 0) begin
        uop_entry_t e;
        e = sb.pop_front();
        chk("iss_uop",  32'(iss_uop),  32'(e.uop));
        chk("iss_k",    32'(iss_k),    32'(e.k));
        chk("iss_last", {31'd0, iss_last}, {31'd0, e.last});
      end
    end
  end

  // One clock of stimulus: drive, check request/occupancy against the model, update model after the edge.
  task automatic cyc(input logic a, input logic [1:0] c,
                     input logic [UOP_W-1:0] u0, input logic [UOP_W-1:0] u1,
                     input logic [UOP_W-1:0] u2, input logic [K_W-1:0] k,
                     input logic pw, input logic rdy, input logic r);
    logic exp_req;
    logic do_enq;
    logic [UOP_W-1:0] lane [3];
    rst = r; ex_feed_ack = a; ex_uop_count = c;
    ex_uop_0 = u0; ex_uop_1 = u1; ex_uop_2 = u2;
    ex_k = k; ex_pc_w = pw; iss_ready = rdy;
    #1;
    exp_req = !r && !pw && ((DEPTH - sb.size()) >= 3);
    chk("feed_req", {31'd0, ex_feed_req}, {31'd0, exp_req});
    if (mon_en) chk("occupancy", 32'(occupancy), 32'(sb.size()));
    do_enq = exp_req && a;
    lane[0] = u0; lane[1] = u1; lane[2] = u2;
    @(posedge clk);
    if (r || pw) begin
      sb.delete();
    end else if (do_enq) begin
      for (int i = 0; i < int'(c); i++) begin
        uop_entry_t e;
        e.uop  = lane[i];
        e.k    = k;
        e.last = (i == int'(c) - 1);
        sb.push_back(e);
      end
    end
    if (r) mon_en = 1'b1;
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 2'd0, '0, '0, '0, '0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    // Reset held two cycles with a full bundle presented.
    cyc(1'b1, 2'd3, 20'h1, 20'h2, 20'h3, 16'h1234, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 2'd3, 20'h1, 20'h2, 20'h3, 16'h1234, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", {31'd0, iss_valid}, 32'd0);
    chk("rst_occ",   32'(occupancy), 32'd0);
    chk("rst_req",   {31'd0, ex_feed_req}, 32'd0);

    // Single bundle, no back-pressure.
    cyc(1'b1, 2'd3, 20'h1, 20'h2, 20'h3, 16'h1234, 1'b0, 1'b1, 1'b0);
    chk("single_head", 32'(iss_uop), 32'h1);
    chk("single_k",    32'(iss_k),   32'h1234);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("single_empty", {31'd0, iss_valid}, 32'd0);

    // Fill with iss_ready low.
    cyc(1'b1, 2'd3, 20'h11, 20'h12, 20'h13, 16'hA001, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 20'h21, 20'h22, 20'h23, 16'hA002, 1'b0, 1'b0, 1'b0);
    chk("fill_occ", 32'(occupancy), 32'd6);
    chk("fill_req", {31'd0, ex_feed_req}, 32'd0);
    cyc(1'b1, 2'd3, 20'h99, 20'h98, 20'h97, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("ignored_ack_occ", 32'(occupancy), 32'd6);
    idle(1'b1);
    chk("deq_occ", 32'(occupancy), 32'd5);
    chk("deq_req", {31'd0, ex_feed_req}, 32'd1);

    // Simultaneous enqueue of 2 and dequeue of 1.
    cyc(1'b1, 2'd2, 20'h31, 20'h32, 20'h0, 16'hA003, 1'b0, 1'b1, 1'b0);
    chk("simul_occ",  32'(occupancy), 32'd6);
    chk("simul_head", 32'(iss_uop),   32'h13);

    // Drain to 4, then flush together with an ack.
    idle(1'b1);
    idle(1'b1);
    chk("preflush_occ", 32'(occupancy), 32'd4);
    cyc(1'b1, 2'd3, 20'h41, 20'h42, 20'h43, 16'hBAD0, 1'b1, 1'b0, 1'b0);
    chk("flush_occ",   32'(occupancy), 32'd0);
    chk("flush_valid", {31'd0, iss_valid}, 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Random bundles across pointer wrap.
    for (int n = 0; n < 50; n++) begin
      cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          20'($urandom), 20'($urandom), 20'($urandom), 16'($urandom),
          1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Bounded drain.
    for (int n = 0; n < 40 && sb.size() != 0; n++) idle(1'b1);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_valid", {31'd0, iss_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uop_issue_queue.md
Name: uop_issue_queue

Overview:
- Execute-side consumer of the front-end micro-op feed handshake: drives ex_feed_req, accepts uop bundles of 0–3 uops plus their 16-bit constant on ex_feed_ack.
- Buffers the uops in a FIFO.
- Issues one uop per cycle to the execution datapath over a valid/ready port.
- Flushes on PC redirect (ex_pc_w), so stale uops from a wrong path never issue.

Parameters:
DEPTH, 8, queue entries (power of two, >= 4)
UOP_W, 20, uop width
K_W, 16, constant operand width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
ex_feed_req  out  1  queue can accept a full bundle
ex_feed_ack  in  1  bundle presented this cycle
ex_uop_0  in  UOP_W  first uop of bundle
ex_uop_1  in  UOP_W  second uop
ex_uop_2  in  UOP_W  third uop
ex_uop_count  in  2  valid uops in bundle, 0..3
ex_k  in  K_W  constant/PC value shared by the bundle
ex_pc_w  in  1  PC redirect from execute; flush
iss_valid  out  1  iss_uop/iss_k valid
iss_ready  in  1  execute consumes head entry
iss_uop  out  UOP_W  head uop
iss_k  out  K_W  constant of head uop's bundle
iss_last  out  1  head uop is last of its bundle
occupancy  out  clog2(DEPTH)+1  entries held (debug/perf)

Behaviour:
- Entry = {uop, k, last}. k is replicated into every entry of a bundle; last is set on entry (count-1) only.
- Registers: rd_ptr and wr_ptr (clog2(DEPTH) bits, wrap modulo DEPTH), cnt (clog2(DEPTH)+1 bits).
- ex_feed_req = ~rst & ~ex_pc_w & (DEPTH - cnt >= 3).
  - Depends on registers, ex_pc_w and rst only; never on ex_feed_ack (no combinational loop).
- Capture: enq = ex_feed_req & ex_feed_ack & ~ex_pc_w.
  - On enq, write ex_uop_0..(count-1) to wr_ptr, wr_ptr+1, wr_ptr+2 (mod DEPTH).
  - Then wr_ptr += count.
  - count = 0: nothing written, pointers unchanged, handshake still completes.
  - ack while req low: ignored, no state change.
- Issue:
  - iss_valid = (cnt != 0).
  - iss_uop, iss_k and iss_last read the head entry combinationally.
  - deq = iss_valid & iss_ready; on deq, rd_ptr += 1.
  - iss_ready with iss_valid low: no effect.
- Latency: bundle accepted in cycle N is visible at the issue port in cycle N+1 when the queue was empty. No same-cycle bypass.
- Simultaneous enq and deq: cnt_next = cnt + count - deq. Worst case cnt+3 <= DEPTH, guaranteed by the req rule; no overflow possible.
- Flush (ex_pc_w=1):
  - Next cycle rd_ptr = wr_ptr = 0 and cnt = 0.
  - A bundle presented the same cycle is discarded.
  - A deq the same cycle is still consumed by execute (the head was valid), but the state is cleared regardless.
  - ex_feed_req is low during the flush cycle.
- Reset (rst=1, any cycle including mid-stream):
  - Next edge: pointers 0, cnt 0, iss_valid 0, occupancy 0.
  - ex_feed_req is 0 while rst is high.
  - Storage contents need no reset.
- Ordering: strict FIFO across pointer wrap; uops within a bundle issue in index order 0,1,2.
- Full: cnt = DEPTH is reachable only via 3-uop bundles when DEPTH is not a multiple of 3. Req is low whenever free < 3.
- Empty: iss_valid low; iss_uop/iss_k are don't-care.

Decomposition:
- Shared package:
  - UOP_W, K_W
  - MAX_BUNDLE = 3
  - entry typedef {last, k, uop}
- One sub-module, uop_queue_mem: DEPTH-entry register array with three write ports (addresses wr_ptr+i, per-lane enables from count) and one async read port at rd_ptr.
- Pointer/count/handshake logic stays in uop_issue_queue.

Test Plan:
- Reset: hold rst 2 cycles with ack=1, count=3 -> ex_feed_req=0, iss_valid=0, occupancy=0. After release, ex_feed_req=1.
- Single bundle, iss_ready=1, no back-pressure: count=3, uops 0x00001/0x00002/0x00003, k=0x1234, ack in cycle N -> in cycles N+1..N+3, iss_uop = 1, 2, 3 with iss_k=0x1234; iss_last=1 only with uop 3; iss_valid=0 in N+4.
- Fill/back-pressure with DEPTH=8, iss_ready=0:
  - Two 3-uop bundles -> occupancy=6, ex_feed_req=0.
  - Third ack held high -> ignored, occupancy stays 6.
  - One deq -> occupancy 5, req=1.
- Simultaneous: occupancy=5, iss_ready=1, ack with count=2 -> occupancy=6 next cycle, head advances by one.
- Flush: occupancy=4, ex_pc_w=1 together with ack (count=3) -> ex_feed_req=0 that cycle; next cycle occupancy=0, iss_valid=0; no discarded uop ever issues.
- Wrap/ordering: 50 bundles with random count 0..3 and random iss_ready -> issued stream equals enqueued stream in order (scoreboard); count=0 bundles add nothing; iss_last marks each bundle's final uop.
